idft_16_seq: RTL and testbench



---
 rtl/idft16_pkg.sv | 47 ++++
 rtl/idft16_twiddle_rom.sv | 48 ++++
 rtl/idft_16_seq.sv | 155 +++++++++++++++
 tb/tb_idft_16_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/idft16_pkg.sv
// ============================================================================
//  Module      : idft16_pkg
//  Description : Shared types and constants for the 16-point sequential
//                inverse DFT: state encoding, transform size and the
//                Q-format twiddle tables (P = 10 fractional bits).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package idft16_pkg;

  localparam int DFT_SIZE  = 16;
  localparam int LOG2_SIZE = 4;
  localparam int TW_P      = 10;
  localparam int TW_W      = TW_P + 2;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // Rounded trig constants shared with the forward DFT (round(x * 2^10)).
  localparam logic signed [TW_W-1:0] TW_COS_PI8  = 12'sd946;  // 0.92387953
  localparam logic signed [TW_W-1:0] TW_SIN_PI8  = 12'sd392;  // 0.38268343
  localparam logic signed [TW_W-1:0] TW_SQRT1_2  = 12'sd724;  // 0.70710678
  localparam logic signed [TW_W-1:0] TW_ONE      = 12'sd1024;

  // cos(2*pi*m/16) and sin(2*pi*m/16), magnitudes rounded half away from
  // zero so that every table sums to exactly zero over a full period.
  localparam logic signed [TW_W-1:0] COS_Q [0:15] = '{
     12'sd1024,  12'sd946,  12'sd724,  12'sd392,
     12'sd0,    -12'sd392, -12'sd724, -12'sd946,
    -12'sd1024, -12'sd946, -12'sd724, -12'sd392,
     12'sd0,     12'sd392,  12'sd724,  12'sd946
  };

  localparam logic signed [TW_W-1:0] SIN_Q [0:15] = '{
     12'sd0,     12'sd392,  12'sd724,  12'sd946,
     12'sd1024,  12'sd946,  12'sd724,  12'sd392,
     12'sd0,    -12'sd392, -12'sd724, -12'sd946,
    -12'sd1024, -12'sd946, -12'sd724, -12'sd392
  };

endpackage

`default_nettype wire

// File: rtl/idft16_twiddle_rom.sv
// ============================================================================
//  Module      : idft16_twiddle_rom
//  Description : Combinational twiddle lookup for W16^(-m) = cos + j*sin.
//                Only the first quarter wave (sin at 0..4 steps) is stored;
//                the other quadrants are folded out by index mirroring and
//                sign inversion.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idft16_twiddle_rom
  import idft16_pkg::*;
#(
  parameter int P = 10
) (
  input  logic [3:0]        m,
  output logic signed [P+1:0] cos_q,
  output logic signed [P+1:0] sin_q
);

  logic [1:0]         w_quad;
  logic [1:0]         w_r;
  logic [2:0]         w_r_inv;
  logic signed [P+1:0] w_qs_r;
  logic signed [P+1:0] w_qs_inv;

  assign w_quad   = m[3:2];
  assign w_r      = m[1:0];
  assign w_r_inv  = 3'd4 - {1'b0, w_r};
  // sin at r steps and sin at (4 - r) steps (the latter equals cos at r).
  assign w_qs_r   = (P+2)'(SIN_Q[{2'b00, w_r}]);
  assign w_qs_inv = (P+2)'(SIN_Q[{1'b0, w_r_inv}]);

  // Fold the quarter-wave values into the quadrant selected by m[3:2].
  always_comb begin
    cos_q = w_qs_inv;
    sin_q = w_qs_r;
    case (w_quad)
      2'd0: begin cos_q =  w_qs_inv; sin_q =  w_qs_r;   end
      2'd1: begin cos_q = -w_qs_r;   sin_q =  w_qs_inv; end
      2'd2: begin cos_q = -w_qs_inv; sin_q = -w_qs_r;   end
      2'd3: begin cos_q =  w_qs_r;   sin_q = -w_qs_inv; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/idft_16_seq.sv
// ============================================================================
//  Module      : idft_16_seq
//  Description : Sequential 16-point inverse DFT. Loads 16 complex bins over
//                a valid/ready stream, evaluates each time sample with one
//                time-multiplexed complex MAC (one term per cycle) and
//                streams the 16 samples out, scaled by 1/16.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idft_16_seq
  import idft16_pkg::*;
#(
  parameter int N = 32,
  parameter int P = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_re,
  input  logic [N-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_re,
  output logic [N-1:0] out_im,
  output logic         out_last,
  output logic         busy
);

  localparam int PW = N + P + 2;   // product width
  localparam int AW = N + P + 6;   // accumulator width (16 terms, no overflow)
  localparam int SH = P + 4;       // twiddle scale plus the 1/16 factor
  localparam logic [LOG2_SIZE-1:0] LAST_IDX = LOG2_SIZE'(DFT_SIZE - 1);

  state_t r_state;
  state_t w_state_next;

  logic [LOG2_SIZE-1:0] r_k;
  logic [LOG2_SIZE-1:0] r_n;
  logic [N-1:0]         r_ram_re [DFT_SIZE];
  logic [N-1:0]         r_ram_im [DFT_SIZE];
  logic signed [AW-1:0] r_acc_re;
  logic signed [AW-1:0] r_acc_im;

  logic                 w_accept;
  logic                 w_out_hs;
  logic [LOG2_SIZE-1:0] w_m;
  logic signed [P+1:0]  w_cos;
  logic signed [P+1:0]  w_sin;
  logic signed [N-1:0]  w_xr;
  logic signed [N-1:0]  w_xi;
  logic signed [PW-1:0] w_p_rc;
  logic signed [PW-1:0] w_p_is;
  logic signed [PW-1:0] w_p_rs;
  logic signed [PW-1:0] w_p_ic;
  logic signed [AW-1:0] w_term_re;
  logic signed [AW-1:0] w_term_im;

  assign w_accept = in_valid && (r_state == LOAD);
  assign w_out_hs = out_ready && (r_state == OUTPUT);

  // Twiddle exponent is n*k mod 16: the 4-bit product keeps only the low bits.
  assign w_m = r_n * r_k;

  idft16_twiddle_rom #(.P(P)) u_twiddle_rom (
    .m     (w_m),
    .cos_q (w_cos),
    .sin_q (w_sin)
  );

  assign w_xr   = $signed(r_ram_re[r_k]);
  assign w_xi   = $signed(r_ram_im[r_k]);
  assign w_p_rc = PW'(w_xr) * PW'(w_cos);
  assign w_p_is = PW'(w_xi) * PW'(w_sin);
  assign w_p_rs = PW'(w_xr) * PW'(w_sin);
  assign w_p_ic = PW'(w_xi) * PW'(w_cos);

  assign w_term_re = AW'(w_p_rc) - AW'(w_p_is);
  assign w_term_im = AW'(w_p_rs) + AW'(w_p_ic);

  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == OUTPUT);
  assign out_last  = (r_state == OUTPUT) && (r_n == LAST_IDX);
  assign busy      = (r_state != LOAD);
  // Arithmetic shift by SH then wrap to N bits is a plain bit slice.
  assign out_re    = r_acc_re[SH +: N];
  assign out_im    = r_acc_im[SH +: N];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_next;
  end

  // Next-state decode: load 16 bins, 16 MAC cycles per sample, then hand off.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD:    if (w_accept && (r_k == LAST_IDX)) w_state_next = COMPUTE;
      COMPUTE: if (r_k == LAST_IDX)               w_state_next = OUTPUT;
      OUTPUT:  if (w_out_hs) w_state_next = (r_n == LAST_IDX) ? LOAD : COMPUTE;
      default: w_state_next = LOAD;
    endcase
  end

  // Bin/sample counters and the complex accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k      <= '0;
      r_n      <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) r_k <= r_k + 1'b1;
          if (w_accept && (r_k == LAST_IDX)) begin
            r_n      <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
          end
        end
        COMPUTE: begin
          r_acc_re <= r_acc_re + w_term_re;
          r_acc_im <= r_acc_im + w_term_im;
          r_k      <= r_k + 1'b1;
        end
        OUTPUT: begin
          if (w_out_hs) begin
            r_n      <= r_n + 1'b1;
            r_k      <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
          end
        end
        default: begin
          r_k <= '0;
          r_n <= '0;
        end
      endcase
    end
  end

  // Bin storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ram_re[r_k] <= in_re;
      r_ram_im[r_k] <= in_im;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_idft_16_seq.sv
// ============================================================================
//  Module      : tb_idft_16_seq
//  Description : Self-checking bench for idft_16_seq. Expected samples come
//                from a direct evaluation of x[n] = floor(sum X[k]W^(-nk)
//                / 2^(P+4)) with twiddles rounded from $cos/$sin.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idft_16_seq;

  localparam int N = 32;
  localparam int P = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_re;
  logic [N-1:0] in_im;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_re;
  logic [N-1:0] out_im;
  logic         out_last;
  logic         busy;

  idft_16_seq #(.N(N), .P(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          fr_re [16];
  int          fr_im [16];
  logic [31:0] exp_re [16];
  logic [31:0] exp_im [16];
  logic [31:0] got_re [16];
  logic [31:0] got_im [16];
  int          first_edge;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rounded twiddle, half away from zero on the magnitude.
  function automatic longint twq(input int m, input bit want_sin);
    real v;
    v = want_sin ? $sin(2.0 * 3.14159265358979 * m / 16.0)
                 : $cos(2.0 * 3.14159265358979 * m / 16.0);
    v = v * 1024.0;
    if (v >= 0.0) return longint'($floor(v + 0.5));
    else          return -longint'($floor(-v + 0.5));
  endfunction

  task automatic build_model();
    longint ar, ai, xr, xi, c, s;
    for (int n = 0; n < 16; n++) begin
      ar = 0; ai = 0;
      for (int k = 0; k < 16; k++) begin
        xr = longint'(fr_re[k]);
        xi = longint'(fr_im[k]);
        c  = twq((n * k) % 16, 1'b0);
        s  = twq((n * k) % 16, 1'b1);
        ar = ar + xr * c - xi * s;
        ai = ai + xr * s + xi * c;
      end
      ar = ar >>> (P + 4);
      ai = ai >>> (P + 4);
      exp_re[n] = ar[31:0];
      exp_im[n] = ai[31:0];
    end
  endtask

  // Offers the current frame; with gaps, in_valid drops at random.
  task automatic send_frame(input bit gaps);
    int   k = 0;
    int   guard = 0;
    logic rdy;
    while (k < 16 && guard < 500) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_re    = fr_re[k];
      in_im    = fr_im[k];
      rdy      = in_ready;
      @(posedge clk); #1;
      guard++;
      if (in_valid && rdy) k++;
    end
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    chk("send_count", 64'(k), 64'd16);
  endtask

  // Called just after the 16th accept edge (edge 0). cyc counts edges since
  // then; a sample seen with out_valid & out_ready completes on edge cyc+1.
  task automatic recv_frame(input int ready_pct, input int stop_at);
    int          n = 0;
    int          cyc = 0;
    bit          hold = 1'b0;
    logic [31:0] h_re, h_im;
    first_edge = -1;
    while (n < stop_at && cyc < 2000) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      in_valid  = $urandom_range(0, 1);
      in_re     = $urandom;
      in_im     = $urandom;
      chk("busy_no_ready", {62'd0, in_ready, busy}, 64'd1);
      if (hold) begin
        chk("stall_re", 64'(out_re), 64'(h_re));
        chk("stall_im", 64'(out_im), 64'(h_im));
      end
      hold = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk($sformatf("re[%0d]", n), 64'(out_re), 64'(exp_re[n]));
          chk($sformatf("im[%0d]", n), 64'(out_im), 64'(exp_im[n]));
          chk($sformatf("last[%0d]", n), 64'(out_last), 64'(n == 15));
          got_re[n] = out_re;
          got_im[n] = out_im;
          if (n == 0) first_edge = cyc + 1;
          n++;
        end else begin
          hold = 1'b1;
          h_re = out_re;
          h_im = out_im;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
    chk("recv_count", 64'(n), 64'(stop_at));
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = 0;
      fr_im[k] = 0;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_re",    64'(out_re),    64'd0);
    chk("rst_out_im",    64'(out_im),    64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Impulse at DC: every sample is (1,0), first handshake on edge 17.
    clear_frame();
    fr_re[0] = 16;
    build_model();
    send_frame(1'b0);
    recv_frame(100, 16);
    chk("latency_impulse", 64'(first_edge), 64'd17);
    chk("impulse_x7_re", 64'(got_re[7]), 64'd1);
    chk("after_frame_in_ready", 64'(in_ready), 64'd1);

    // Flat spectrum: only x[0] is nonzero if the twiddles sum to zero.
    for (int k = 0; k < 16; k++) fr_re[k] = 16;
    build_model();
    send_frame(1'b0);
    recv_frame(100, 16);
    chk("flat_x0_re", 64'(got_re[0]), 64'd16);
    chk("flat_x5_re", 64'(got_re[5]), 64'd0);
    chk("flat_x5_im", 64'(got_im[5]), 64'd0);

    // Single bin at k=1: outputs reproduce the twiddle table.
    clear_frame();
    fr_re[1] = 16384;
    build_model();
    send_frame(1'b0);
    recv_frame(100, 16);
    chk("bin1_x0_re",  64'(got_re[0]),  64'd1024);
    chk("bin1_x1_re",  64'(got_re[1]),  64'd946);
    chk("bin1_x1_im",  64'(got_im[1]),  64'd392);
    chk("bin1_x2_re",  64'(got_re[2]),  64'd724);
    chk("bin1_x2_im",  64'(got_im[2]),  64'd724);
    chk("bin1_x4_im",  64'(got_im[4]),  64'd1024);
    chk("bin1_x8_re",  64'(got_re[8]),  64'h0000_0000_FFFF_FC00);
    chk("bin1_x12_im", 64'(got_im[12]), 64'h0000_0000_FFFF_FC00);

    // Random full-range frames with gapped input and 50% output backpressure.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) begin
        fr_re[k] = int'($urandom);
        fr_im[k] = int'($urandom);
      end
      build_model();
      send_frame(1'b1);
      recv_frame(50, 16);
    end

    // Reset while computing sample 5, then the impulse frame must come out clean.
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = int'($urandom);
      fr_im[k] = int'($urandom);
    end
    build_model();
    send_frame(1'b1);
    recv_frame(100, 5);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy",      64'(busy),      64'd0);
    chk("midrst_out_re",    64'(out_re),    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_frame();
    fr_re[0] = 16;
    build_model();
    send_frame(1'b0);
    recv_frame(100, 16);
    chk("latency_after_rst", 64'(first_edge), 64'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
